// File: rtl/pet_pkg.sv
// Shared constants and saturating arithmetic for the pet attribute controller.
// Attribute index names match the channels the state controller drives.
package pet_pkg;

   localparam int unsigned DEF_INIT_VAL = 32'd128;
   localparam int unsigned DEF_ACT_STEP = 32'd16;
   localparam int unsigned DEF_LIMIAR   = 32'd32;
   localparam int unsigned DEF_TICK_DIV = 32'd50_000_000;

   localparam int ATR_FOME       = 32'd0;
   localparam int ATR_FELICIDADE = 32'd1;
   localparam int ATR_SONO       = 32'd2;

   // Subtraction clamped at zero; operands are wider than any attribute so nothing wraps.
   function automatic int unsigned sat_sub(input int unsigned v, input int unsigned s);
      int unsigned r;
      if (v > s) begin
         r = v - s;
      end else begin
         r = 32'd0;
      end
      return r;
   endfunction

   function automatic int unsigned sat_add(input int unsigned v, input int unsigned s,
                                           input int unsigned max_v);
      int unsigned r;
      if ((v + s) > max_v) begin
         r = max_v;
      end else begin
         r = v + s;
      end
      return r;
   endfunction

endpackage

// File: rtl/canal_atributo.sv
// One attribute channel: value register with decay-then-action update and
// a registered low-level alert flag.
module canal_atributo
   import pet_pkg::*;
#(
   parameter int unsigned W          = 32'd8,
   parameter int unsigned INIT_VAL   = 32'd128,
   parameter int unsigned MAX_VAL    = 32'd255,
   parameter int unsigned DECAY_STEP = 32'd1,
   parameter int unsigned ACT_STEP   = 32'd16,
   parameter int unsigned LIMIAR     = 32'd32
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         tick_i,
   input  logic         acao,
   input  logic         load_init,
   input  logic         freeze,
   output logic [W-1:0] value,
   output logic         is_zero,
   output logic         alerta
);

   localparam logic [W-1:0] INIT_W     = W'(INIT_VAL);
   localparam logic         ALERTA_INI = (INIT_VAL < LIMIAR);

   logic [W-1:0] value_r;
   logic         alerta_r;
   logic [W-1:0] decay_s;
   logic [W-1:0] next_s;
   logic         next_low_s;

   // Post-update value: decay first, then the action restore on top of it.
   always_comb begin
      decay_s    = value_r;
      next_s     = value_r;
      next_low_s = 1'b0;
      if (tick_i) begin
         decay_s = W'(sat_sub(32'(value_r), DECAY_STEP));
      end else begin
         decay_s = value_r;
      end
      if (acao) begin
         next_s = W'(sat_add(32'(decay_s), ACT_STEP, MAX_VAL));
      end else begin
         next_s = decay_s;
      end
      next_low_s = (32'(next_s) < LIMIAR);
   end

   // Value and alert registers; revive reloads, a dead pet freezes.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         value_r  <= INIT_W;
         alerta_r <= ALERTA_INI;
      end else if (load_init) begin
         value_r  <= INIT_W;
         alerta_r <= ALERTA_INI;
      end else if (freeze) begin
         value_r  <= value_r;
         alerta_r <= alerta_r;
      end else begin
         value_r  <= next_s;
         alerta_r <= next_low_s;
      end
   end

   assign value   = value_r;
   assign alerta  = alerta_r;
   assign is_zero = (next_s == {W{1'b0}});

endmodule

// File: rtl/controlador_atributos_n.sv
// N-channel pet attribute controller: shared decay prescaler, grace-period
// death detector with revive, and packing of the channel values.
module controlador_atributos_n
   import pet_pkg::*;
#(
   parameter int unsigned N_ATR       = 32'd3,
   parameter int unsigned W           = 32'd8,
   parameter int unsigned INIT_VAL    = DEF_INIT_VAL,
   parameter int unsigned MAX_VAL     = 32'd255,
   parameter int unsigned DECAY_STEP  = 32'd1,
   parameter int unsigned ACT_STEP    = DEF_ACT_STEP,
   parameter int unsigned LIMIAR      = DEF_LIMIAR,
   parameter int unsigned TICK_DIV    = DEF_TICK_DIV,
   parameter int unsigned DEATH_TICKS = 32'd8
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [N_ATR-1:0]   acao,
   input  logic               pausa,
   input  logic               reviver,
   output logic [N_ATR*W-1:0] valores,
   output logic [N_ATR-1:0]   alerta,
   output logic               tick,
   output logic               morreu
);

   localparam int unsigned CW = (TICK_DIV > 32'd1) ? $clog2(TICK_DIV) : 32'd1;
   localparam int unsigned ZW = $clog2(DEATH_TICKS + 32'd1);
   localparam logic [CW-1:0] CNT_MAX = CW'(TICK_DIV - 32'd1);
   localparam logic [ZW-1:0] ZC_MAX  = ZW'(DEATH_TICKS);

   logic [CW-1:0]    cnt_r;
   logic [ZW-1:0]    zc_r;
   logic [ZW-1:0]    zc_inc_s;
   logic             morreu_r;
   logic             tick_r;
   logic             tick_s;
   logic             load_init_s;
   logic             any_zero_s;
   logic [N_ATR-1:0] is_zero_s;

   assign tick_s      = (cnt_r == CNT_MAX) & ~pausa & ~morreu_r;
   assign load_init_s = reviver & morreu_r;
   assign any_zero_s  = |is_zero_s;
   assign zc_inc_s    = zc_r + ZW'(1);

   for (genvar i = 0; i < int'(N_ATR); i++) begin : g_canal
      canal_atributo #(
         .W          (W),
         .INIT_VAL   (INIT_VAL),
         .MAX_VAL    (MAX_VAL),
         .DECAY_STEP (DECAY_STEP),
         .ACT_STEP   (ACT_STEP),
         .LIMIAR     (LIMIAR)
      ) u_canal (
         .clk       (clk),
         .rst_n     (rst_n),
         .tick_i    (tick_s),
         .acao      (acao[i]),
         .load_init (load_init_s),
         .freeze    (morreu_r),
         .value     (valores[i*W +: W]),
         .is_zero   (is_zero_s[i]),
         .alerta    (alerta[i])
      );
   end

   // Prescaler, zero-run counter and death/revive state.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt_r    <= {CW{1'b0}};
         zc_r     <= {ZW{1'b0}};
         morreu_r <= 1'b0;
         tick_r   <= 1'b0;
      end else if (load_init_s) begin
         cnt_r    <= {CW{1'b0}};
         zc_r     <= {ZW{1'b0}};
         morreu_r <= 1'b0;
         tick_r   <= 1'b0;
      end else if (morreu_r) begin
         cnt_r    <= {CW{1'b0}};
         tick_r   <= 1'b0;
      end else begin
         tick_r <= tick_s;
         if (pausa) begin
            cnt_r <= cnt_r;
         end else if (cnt_r == CNT_MAX) begin
            cnt_r <= {CW{1'b0}};
         end else begin
            cnt_r <= cnt_r + CW'(1);
         end
         // Death is judged on tick edges only, from the post-update values.
         if (tick_s) begin
            if (any_zero_s) begin
               zc_r <= zc_inc_s;
               if (zc_inc_s == ZC_MAX) begin
                  morreu_r <= 1'b1;
               end else begin
                  morreu_r <= 1'b0;
               end
            end else begin
               zc_r <= {ZW{1'b0}};
            end
         end else begin
            zc_r <= zc_r;
         end
      end
   end

   assign tick   = tick_r;
   assign morreu = morreu_r;

endmodule

// File: tb/tb_controlador_atributos_n.sv
// Bench for controlador_atributos_n: two instances (INIT 128 and INIT 1) run
// directed scenarios and random traffic against a behavioural model.
module tb_controlador_atributos_n;

   localparam int TD  = 4;
   localparam int DT  = 2;
   localparam int MXV = 255;
   localparam int ACT = 16;
   localparam int LIM = 32;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n_a, pausa_a, rev_a, tick_a, morreu_a;
   logic [2:0]  acao_a, alerta_a;
   logic [23:0] val_a;
   logic        rst_n_b, pausa_b, rev_b, tick_b, morreu_b;
   logic [2:0]  acao_b, alerta_b;
   logic [23:0] val_b;

   controlador_atributos_n #(.N_ATR(3), .W(8), .INIT_VAL(128), .MAX_VAL(255), .DECAY_STEP(1),
      .ACT_STEP(16), .LIMIAR(32), .TICK_DIV(4), .DEATH_TICKS(2)) dut_a (
      .clk(clk), .rst_n(rst_n_a), .acao(acao_a), .pausa(pausa_a), .reviver(rev_a),
      .valores(val_a), .alerta(alerta_a), .tick(tick_a), .morreu(morreu_a));

   controlador_atributos_n #(.N_ATR(3), .W(8), .INIT_VAL(1), .MAX_VAL(255), .DECAY_STEP(1),
      .ACT_STEP(16), .LIMIAR(32), .TICK_DIV(4), .DEATH_TICKS(2)) dut_b (
      .clk(clk), .rst_n(rst_n_b), .acao(acao_b), .pausa(pausa_b), .reviver(rev_b),
      .valores(val_b), .alerta(alerta_b), .tick(tick_b), .morreu(morreu_b));

   int n_tests = 0;
   int n_fail  = 0;

   int mv [2][3];
   int mcnt [2];
   int mzc [2];
   bit mdead [2];
   bit mtick [2];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // Behavioural model: one clock edge of the attribute rules.
   task model_step(input int k, input logic r, input logic [2:0] a, input logic p,
                   input logic rv, input int init);
      int d;
      bit ti, anyz;
      if (!r) begin
         for (int i = 0; i < 3; i++) mv[k][i] = init;
         mcnt[k] = 0; mzc[k] = 0; mdead[k] = 0; mtick[k] = 0;
      end else if (mdead[k] && rv) begin
         for (int i = 0; i < 3; i++) mv[k][i] = init;
         mcnt[k] = 0; mzc[k] = 0; mdead[k] = 0; mtick[k] = 0;
      end else if (mdead[k]) begin
         mtick[k] = 0; mcnt[k] = 0;
      end else begin
         ti = (mcnt[k] == TD - 1) && !p;
         anyz = 0;
         for (int i = 0; i < 3; i++) begin
            d = mv[k][i];
            if (ti) d = (d > 0) ? d - 1 : 0;
            if (a[i]) d = (d + ACT > MXV) ? MXV : d + ACT;
            mv[k][i] = d;
            if (d == 0) anyz = 1;
         end
         mtick[k] = ti;
         if (!p) mcnt[k] = (mcnt[k] + 1) % TD;
         if (ti) begin
            if (anyz) begin
               mzc[k]++;
               if (mzc[k] == DT) begin
                  mdead[k] = 1; mcnt[k] = 0;
               end
            end else begin
               mzc[k] = 0;
            end
         end
      end
   endtask

   always @(posedge clk) begin
      model_step(0, rst_n_a, acao_a, pausa_a, rev_a, 128);
      model_step(1, rst_n_b, acao_b, pausa_b, rev_b, 1);
   end

   function automatic logic [23:0] exp_val(input int k);
      return {mv[k][2][7:0], mv[k][1][7:0], mv[k][0][7:0]};
   endfunction

   function automatic logic [2:0] exp_al(input int k);
      return {mv[k][2] < LIM, mv[k][1] < LIM, mv[k][0] < LIM};
   endfunction

   task automatic compare_all();
      chk("a_valores", 32'(val_a), 32'(exp_val(0)));
      chk("a_alerta",  32'(alerta_a), 32'(exp_al(0)));
      chk("a_tick",    32'(tick_a), 32'(mtick[0]));
      chk("a_morreu",  32'(morreu_a), 32'(mdead[0]));
      chk("b_valores", 32'(val_b), 32'(exp_val(1)));
      chk("b_alerta",  32'(alerta_b), 32'(exp_al(1)));
      chk("b_tick",    32'(tick_b), 32'(mtick[1]));
      chk("b_morreu",  32'(morreu_b), 32'(mdead[1]));
   endtask

   task automatic step();
      @(posedge clk);
      @(negedge clk);
      compare_all();
   endtask

   // Steps until the chosen instance pulses tick; an expired budget counts as a failure.
   task automatic wait_tick(input int k, input int budget);
      bit seen;
      seen = 0;
      for (int n = 0; n < budget && !seen; n++) begin
         step();
         seen = (k == 0) ? tick_a : tick_b;
      end
      if (!seen) chk("tick_timeout", 32'd0, 32'd1);
   endtask

   initial begin
      int ticks;
      rst_n_a = 1'b0; acao_a = 3'b000; pausa_a = 1'b0; rev_a = 1'b0;
      rst_n_b = 1'b0; acao_b = 3'b000; pausa_b = 1'b0; rev_b = 1'b0;

      // 1: reset state and steady decay
      step(); step();
      chk("t1_reset_val", 32'(val_a), 32'h00808080);
      chk("t1_reset_alerta", 32'(alerta_a), 32'd0);
      chk("t1_reset_morreu", 32'(morreu_a), 32'd0);
      rst_n_a = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         chk("t1_no_early_tick", 32'(tick_a), 32'd0);
      end
      step();
      chk("t1_first_tick", 32'(tick_a), 32'd1);
      chk("t1_first_val", 32'(val_a), 32'h007F7F7F);
      ticks = 1;
      for (int n = 0; n < 400 && ticks < 40; n++) begin
         step();
         if (tick_a) ticks++;
      end
      chk("t1_40_ticks", 32'(ticks), 32'd40);
      chk("t1_val_88", 32'(val_a), 32'h00585858);

      // 2: upward saturation while paused
      rst_n_a = 1'b0; step();
      rst_n_a = 1'b1; pausa_a = 1'b1; acao_a = 3'b001;
      for (int i = 0; i < 9; i++) begin
         step();
         chk("t2_ch0", 32'(val_a[7:0]), (128 + 16 * (i + 1) > 255) ? 32'd255 : 32'(128 + 16 * (i + 1)));
         chk("t2_ch21", 32'(val_a[23:8]), 32'h00008080);
         chk("t2_no_tick", 32'(tick_a), 32'd0);
      end
      acao_a = 3'b000;

      // 6: pause with one action, then reset during an action
      rst_n_a = 1'b0; step();
      rst_n_a = 1'b1;
      for (int i = 0; i < 20; i++) begin
         acao_a = (i == 5) ? 3'b100 : 3'b000;
         step();
         chk("t6_paused_tick", 32'(tick_a), 32'd0);
         if (i == 5) chk("t6_ch2_144", 32'(val_a), 32'h00908080);
      end
      pausa_a = 1'b0;
      step(); step(); step();
      rst_n_a = 1'b0; acao_a = 3'b111;
      step();
      chk("t6_reset_val", 32'(val_a), 32'h00808080);
      rst_n_a = 1'b1; acao_a = 3'b000;
      for (int i = 0; i < 3; i++) begin
         step();
         chk("t6_no_early_tick", 32'(tick_a), 32'd0);
      end
      step();
      chk("t6_restart_tick", 32'(tick_a), 32'd1);

      // 4: death with INIT=1, then freeze
      rst_n_b = 1'b1;
      wait_tick(1, 8);
      chk("t4_all_zero", 32'(val_b), 32'd0);
      chk("t4_alerta", 32'(alerta_b), 32'd7);
      chk("t4_alive", 32'(morreu_b), 32'd0);
      wait_tick(1, 8);
      chk("t4_dead", 32'(morreu_b), 32'd1);
      acao_b = 3'b111;
      for (int i = 0; i < 20; i++) begin
         step();
         chk("t4_frozen", 32'(val_b), 32'd0);
         chk("t4_no_tick", 32'(tick_b), 32'd0);
      end
      acao_b = 3'b000;

      // 5: revive, then a revive pulse while alive
      rev_b = 1'b1; step(); rev_b = 1'b0;
      chk("t5_val", 32'(val_b), 32'h00010101);
      chk("t5_alive", 32'(morreu_b), 32'd0);
      for (int i = 0; i < 3; i++) begin
         step();
         chk("t5_no_early_tick", 32'(tick_b), 32'd0);
      end
      step();
      chk("t5_tick", 32'(tick_b), 32'd1);
      rev_b = 1'b1; step(); rev_b = 1'b0;
      chk("t5_rev_alive_val", 32'(val_b), 32'd0);
      chk("t5_rev_alive_m", 32'(morreu_b), 32'd0);

      // 3: action coinciding with a tick while at zero
      rst_n_b = 1'b0; step(); rst_n_b = 1'b1;
      wait_tick(1, 8);
      step(); step(); step();
      acao_b = 3'b010;
      step();
      acao_b = 3'b000;
      chk("t3_tick", 32'(tick_b), 32'd1);
      chk("t3_val", 32'(val_b), 32'h00001000);

      // Random traffic on both instances
      for (int n = 0; n < 600; n++) begin
         rst_n_a = ($urandom_range(63) != 0);
         rst_n_b = ($urandom_range(63) != 0);
         pausa_a = ($urandom_range(3) == 0);
         pausa_b = ($urandom_range(3) == 0);
         rev_a   = ($urandom_range(7) == 0);
         rev_b   = ($urandom_range(7) == 0);
         for (int i = 0; i < 3; i++) begin
            acao_a[i] = ($urandom_range(5) == 0);
            acao_b[i] = ($urandom_range(9) == 0);
         end
         step();
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
